// File: rtl/dual_gshare_predictor.sv
// dual_gshare_predictor: dual-lane BTB + gshare predictor; return stack enabled by BP_RAS_EN
module dual_gshare_predictor #(
  parameter int BTB_ENTRIES = 16,
  parameter int PHT_BITS = 9,
  parameter int HIST_BITS = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic [31:0] pc_f,
  output logic        hit_f1,
  output logic        hit_f2,
  output logic        pred_f1,
  output logic        pred_f2,
  output logic [31:0] tgt_f1,
  output logic [31:0] tgt_f2,
  output logic [31:0] pc_next,
  output logic        flush_f,
  input  logic        res_v1,
  input  logic        res_v2,
  input  logic [31:0] res_pc1,
  input  logic [31:0] res_pc2,
  input  logic [1:0]  res_type1,
  input  logic [1:0]  res_type2,
  input  logic        res_taken1,
  input  logic        res_taken2,
  input  logic [31:0] res_tgt1,
  input  logic [31:0] res_tgt2,
  input  logic        res_pred1,
  input  logic        res_pred2,
  input  logic [31:0] res_ptgt1,
  input  logic [31:0] res_ptgt2
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IDX;
  localparam int PN = 1 << PHT_BITS;

  logic              btb_v   [BTB_ENTRIES];
  logic [TW-1:0]     btb_tag [BTB_ENTRIES];
  logic [31:0]       btb_tgt [BTB_ENTRIES];
  logic [1:0]        btb_ty  [BTB_ENTRIES];
  logic [1:0]        pht     [PN];
  logic [HIST_BITS-1:0] ghr, ghr_mid, ghr_n;

  logic [31:0]       fpc [2];
  logic [IDX-1:0]    fi  [2];
  logic              fhit [2], fpred [2];
  logic [31:0]       ftgt [2];

  logic [31:0]       rpc [2], rtgt [2], rptgt [2];
  logic [1:0]        rty [2];
  logic              rv [2], rtk [2], rpr [2];
  logic [IDX-1:0]    bi [2];
  logic [PHT_BITS-1:0] pi [2];
  logic              rhit [2], mraw [2], mis [2], upd [2], cnd [2], bwr [2];

  logic              ras_ne;
  logic [31:0]       ras_top;

  function automatic logic [IDX-1:0] bidx(input logic [31:0] pc);
    return pc[IDX+1:2];
  endfunction

  function automatic logic [TW-1:0] btag(input logic [31:0] pc);
    return pc[31:IDX+2];
  endfunction

  function automatic logic [PHT_BITS-1:0] pidx(input logic [31:0] pc, input logic [HIST_BITS-1:0] g);
    return pc[PHT_BITS+1:2] ^ PHT_BITS'(g);
  endfunction

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    return t ? (c == 2'b11 ? c : c + 2'b01) : (c == 2'b00 ? c : c - 2'b01);
  endfunction

  assign fpc[0] = pc_f;
  assign fpc[1] = pc_f + 32'd4;
  assign rpc[0] = res_pc1;
  assign rpc[1] = res_pc2;
  assign rtgt[0] = res_tgt1;
  assign rtgt[1] = res_tgt2;
  assign rptgt[0] = res_ptgt1;
  assign rptgt[1] = res_ptgt2;
  assign rty[0] = res_type1;
  assign rty[1] = res_type2;
  assign rv[0] = res_v1;
  assign rv[1] = res_v2;
  assign rtk[0] = res_taken1;
  assign rtk[1] = res_taken2;
  assign rpr[0] = res_pred1;
  assign rpr[1] = res_pred2;

  // Fetch-side lookup: BTB hit, direction from gshare (or forced for jumps), target from RAS or BTB
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fi[i] = bidx(fpc[i]);
      fhit[i] = btb_v[fi[i]] && btb_tag[fi[i]] == btag(fpc[i]);
      fpred[i] = fhit[i] && (btb_ty[fi[i]] != 2'b00 || pht[pidx(fpc[i], ghr)][1]);
      ftgt[i] = !fhit[i] ? 32'd0 : (ras_ne && btb_ty[fi[i]] == 2'b11) ? ras_top : btb_tgt[fi[i]];
    end
  end

  assign hit_f1 = fhit[0];
  assign hit_f2 = fhit[1];
  assign pred_f1 = fpred[0];
  assign pred_f2 = fpred[1];
  assign tgt_f1 = ftgt[0];
  assign tgt_f2 = ftgt[1];

  // Resolve-side classification: mispredicts, lane2 squash/skip, and BTB write decisions
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bi[i] = bidx(rpc[i]);
      pi[i] = pidx(rpc[i], ghr);
      rhit[i] = btb_v[bi[i]] && btb_tag[bi[i]] == btag(rpc[i]);
      mraw[i] = rv[i] && (rtk[i] != rpr[i] || (rtk[i] && rtgt[i] != rptgt[i]));
    end
    mis[0] = mraw[0];
    mis[1] = mraw[1] && !mraw[0];
    upd[0] = rv[0];
    upd[1] = rv[1] && !mraw[0] && !(rv[0] && rtk[0]);
    for (int i = 0; i < 2; i++) begin
      cnd[i] = upd[i] && rty[i] == 2'b00;
      bwr[i] = upd[i] && rtk[i] && (!rhit[i] || btb_tgt[bi[i]] != rtgt[i] || btb_ty[bi[i]] != rty[i]);
    end
  end

  assign flush_f = mis[0] || mis[1];
  assign pc_next = mis[0] ? (rtk[0] ? rtgt[0] : rpc[0] + 32'd4) :
                   mis[1] ? (rtk[1] ? rtgt[1] : rpc[1] + 32'd4) :
                   fpred[0] ? ftgt[0] : fpred[1] ? ftgt[1] : pc_f + 32'd8;

  // History advances once per resolved conditional, lane1 outcome shifted in first
  always_comb begin
    ghr_mid = cnd[0] ? ((ghr << 1) | HIST_BITS'(rtk[0])) : ghr;
    ghr_n = cnd[1] ? ((ghr_mid << 1) | HIST_BITS'(rtk[1])) : ghr_mid;
  end

  // BTB/PHT/history state; lane2 written before lane1 so lane1 wins a same-index conflict
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) btb_v[i] <= 1'b0;
      for (int i = 0; i < PN; i++) pht[i] <= 2'b01;
    end else if (!stall_f) begin
      ghr <= ghr_n;
      for (int i = 1; i >= 0; i--) begin
        if (cnd[i]) pht[pi[i]] <= sat(pht[pi[i]], rtk[i]);
        if (bwr[i]) begin
          btb_v[bi[i]] <= 1'b1;
          btb_tag[bi[i]] <= btag(rpc[i]);
          btb_tgt[bi[i]] <= rtgt[i];
          btb_ty[bi[i]] <= rty[i];
        end
      end
    end
  end

`ifdef BP_RAS_EN
  localparam int RP = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
  localparam int RC = $clog2(RAS_DEPTH + 1);

  logic [31:0]   ras [RAS_DEPTH];
  logic [RP-1:0] ras_ptr, ras_ptr_n;
  logic [RC-1:0] ras_cnt, ras_cnt_n;
  logic [RP-1:0] wp [2];
  logic          push [2];

  assign ras_ne = ras_cnt != '0;
  assign ras_top = ras[ras_ptr - RP'(1)];

  // Apply lane1 then lane2 push/pop to a running pointer and count
  always_comb begin
    ras_ptr_n = ras_ptr;
    ras_cnt_n = ras_cnt;
    for (int i = 0; i < 2; i++) begin
      push[i] = upd[i] && rtk[i] && rty[i] == 2'b10;
      wp[i] = ras_ptr_n;
      if (push[i]) begin
        ras_ptr_n = ras_ptr_n + RP'(1);
        ras_cnt_n = ras_cnt_n == RC'(RAS_DEPTH) ? ras_cnt_n : ras_cnt_n + RC'(1);
      end else if (upd[i] && rty[i] == 2'b11 && ras_cnt_n != '0) begin
        ras_ptr_n = ras_ptr_n - RP'(1);
        ras_cnt_n = ras_cnt_n - RC'(1);
      end
    end
  end

  // Return stack storage; a push when full overwrites the oldest slot via pointer wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (!stall_f) begin
      ras_ptr <= ras_ptr_n;
      ras_cnt <= ras_cnt_n;
      for (int i = 0; i < 2; i++)
        if (push[i]) ras[wp[i]] <= rpc[i] + 32'd4;
    end
  end
`else
  assign ras_ne = 1'b0;
  assign ras_top = 32'd0;
`endif

endmodule

// File: tb/tb_dual_gshare_predictor.sv
// tb_dual_gshare_predictor: directed checks of prediction, resolve, flush, stall and return stack
module tb_dual_gshare_predictor;
  logic        clk = 1'b0;
  logic        reset, stall_f;
  logic [31:0] pc_f;
  logic        hit_f1, hit_f2, pred_f1, pred_f2, flush_f;
  logic [31:0] tgt_f1, tgt_f2, pc_next;
  logic        res_v1, res_v2, res_taken1, res_taken2, res_pred1, res_pred2;
  logic [31:0] res_pc1, res_pc2, res_tgt1, res_tgt2, res_ptgt1, res_ptgt2;
  logic [1:0]  res_type1, res_type2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_gshare_predictor #(.BTB_ENTRIES(16), .PHT_BITS(9), .HIST_BITS(1), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .pc_f(pc_f),
    .hit_f1(hit_f1), .hit_f2(hit_f2), .pred_f1(pred_f1), .pred_f2(pred_f2),
    .tgt_f1(tgt_f1), .tgt_f2(tgt_f2), .pc_next(pc_next), .flush_f(flush_f),
    .res_v1(res_v1), .res_v2(res_v2), .res_pc1(res_pc1), .res_pc2(res_pc2),
    .res_type1(res_type1), .res_type2(res_type2), .res_taken1(res_taken1), .res_taken2(res_taken2),
    .res_tgt1(res_tgt1), .res_tgt2(res_tgt2), .res_pred1(res_pred1), .res_pred2(res_pred2),
    .res_ptgt1(res_ptgt1), .res_ptgt2(res_ptgt2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    res_v1 = 0; res_pc1 = 0; res_type1 = 0; res_taken1 = 0; res_tgt1 = 0; res_pred1 = 0; res_ptgt1 = 0;
    res_v2 = 0; res_pc2 = 0; res_type2 = 0; res_taken2 = 0; res_tgt2 = 0; res_pred2 = 0; res_ptgt2 = 0;
  endtask

  task automatic drive1(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                        input logic [31:0] tgt, input logic pr, input logic [31:0] ptgt);
    res_v1 = 1; res_pc1 = pc; res_type1 = ty; res_taken1 = tk; res_tgt1 = tgt; res_pred1 = pr; res_ptgt1 = ptgt;
  endtask

  task automatic drive2(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                        input logic [31:0] tgt, input logic pr, input logic [31:0] ptgt);
    res_v2 = 1; res_pc2 = pc; res_type2 = ty; res_taken2 = tk; res_tgt2 = tgt; res_pred2 = pr; res_ptgt2 = ptgt;
  endtask

  task automatic do_reset;
    reset = 1; stall_f = 0; pc_f = 0; idle;
    tick; tick;
    reset = 0;
  endtask

  task automatic test_reset;
    do_reset;
    pc_f = 32'h100; #1;
    checks++; if (hit_f1 !== 1'b0) begin errors++; $display("FAIL reset_hit1 got %0h exp 0", hit_f1); end
    checks++; if (hit_f2 !== 1'b0) begin errors++; $display("FAIL reset_hit2 got %0h exp 0", hit_f2); end
    checks++; if (pred_f1 !== 1'b0) begin errors++; $display("FAIL reset_pred1 got %0h exp 0", pred_f1); end
    checks++; if (tgt_f1 !== 32'h0) begin errors++; $display("FAIL reset_tgt1 got %0h exp 0", tgt_f1); end
    checks++; if (flush_f !== 1'b0) begin errors++; $display("FAIL reset_flush got %0h exp 0", flush_f); end
    checks++; if (pc_next !== 32'h108) begin errors++; $display("FAIL reset_pc_next got %0h exp 108", pc_next); end
  endtask

  task automatic test_cold_miss;
    drive1(32'h100, 2'b00, 1, 32'h200, 0, 32'h0); #1;
    checks++; if (flush_f !== 1'b1) begin errors++; $display("FAIL cold_flush got %0h exp 1", flush_f); end
    checks++; if (pc_next !== 32'h200) begin errors++; $display("FAIL cold_redirect got %0h exp 200", pc_next); end
    tick; idle; pc_f = 32'h100; #1;
    checks++; if (hit_f1 !== 1'b1) begin errors++; $display("FAIL cold_hit got %0h exp 1", hit_f1); end
    checks++; if (tgt_f1 !== 32'h200) begin errors++; $display("FAIL cold_tgt got %0h exp 200", tgt_f1); end
    checks++; if (pred_f1 !== 1'b0) begin errors++; $display("FAIL cold_pred_newghr got %0h exp 0", pred_f1); end
    checks++; if (pc_next !== 32'h108) begin errors++; $display("FAIL cold_pc_next got %0h exp 108", pc_next); end
  endtask

  task automatic test_counter_training;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      drive1(32'h40, 2'b00, 1, 32'h80, 1, 32'h80); tick;
      drive1(32'h300, 2'b00, 0, 32'h0, 0, 32'h0); tick;
    end
    idle; pc_f = 32'h40; #1;
    checks++; if (pred_f1 !== 1'b1) begin errors++; $display("FAIL train_pred got %0h exp 1", pred_f1); end
    checks++; if (tgt_f1 !== 32'h80) begin errors++; $display("FAIL train_tgt got %0h exp 80", tgt_f1); end
    checks++; if (pc_next !== 32'h80) begin errors++; $display("FAIL train_pc_next got %0h exp 80", pc_next); end
    pc_f = 32'h3C; #1;
    checks++; if (hit_f1 !== 1'b0) begin errors++; $display("FAIL lane2_hit1 got %0h exp 0", hit_f1); end
    checks++; if (pred_f2 !== 1'b1) begin errors++; $display("FAIL lane2_pred got %0h exp 1", pred_f2); end
    checks++; if (pc_next !== 32'h80) begin errors++; $display("FAIL lane2_pc_next got %0h exp 80", pc_next); end
    drive1(32'h40, 2'b00, 0, 32'h0, 1, 32'h80); #1;
    checks++; if (flush_f !== 1'b1) begin errors++; $display("FAIL nt_flush got %0h exp 1", flush_f); end
    checks++; if (pc_next !== 32'h44) begin errors++; $display("FAIL nt_redirect got %0h exp 44", pc_next); end
    tick; idle; pc_f = 32'h40; #1;
    checks++; if (pred_f1 !== 1'b1) begin errors++; $display("FAIL ctr10_pred got %0h exp 1", pred_f1); end
    drive1(32'h40, 2'b00, 0, 32'h0, 1, 32'h80); tick; idle; #1;
    checks++; if (pred_f1 !== 1'b0) begin errors++; $display("FAIL ctr01_pred got %0h exp 0", pred_f1); end
    checks++; if (pc_next !== 32'h48) begin errors++; $display("FAIL ctr01_pc_next got %0h exp 48", pc_next); end
  endtask

  task automatic test_dual_resolve;
    do_reset;
    pc_f = 32'h200;
    drive1(32'h80, 2'b00, 0, 32'h0, 1, 32'h0);
    drive2(32'h90, 2'b01, 1, 32'h500, 0, 32'h0); #1;
    checks++; if (flush_f !== 1'b1) begin errors++; $display("FAIL dual_flush got %0h exp 1", flush_f); end
    checks++; if (pc_next !== 32'h84) begin errors++; $display("FAIL dual_redirect got %0h exp 84", pc_next); end
    tick; idle; pc_f = 32'h90; #1;
    checks++; if (hit_f1 !== 1'b0) begin errors++; $display("FAIL dual_squash_btb got %0h exp 0", hit_f1); end
    drive1(32'hA0, 2'b00, 0, 32'h0, 0, 32'h0);
    drive2(32'hA4, 2'b01, 1, 32'h600, 0, 32'h0); #1;
    checks++; if (flush_f !== 1'b1) begin errors++; $display("FAIL lane2_mis_flush got %0h exp 1", flush_f); end
    checks++; if (pc_next !== 32'h600) begin errors++; $display("FAIL lane2_mis_redirect got %0h exp 600", pc_next); end
    tick; idle; pc_f = 32'hA0; #1;
    checks++; if (hit_f1 !== 1'b0) begin errors++; $display("FAIL nt_no_alloc got %0h exp 0", hit_f1); end
    checks++; if (hit_f2 !== 1'b1) begin errors++; $display("FAIL lane2_alloc got %0h exp 1", hit_f2); end
    checks++; if (tgt_f2 !== 32'h600) begin errors++; $display("FAIL lane2_tgt got %0h exp 600", tgt_f2); end
    checks++; if (pc_next !== 32'h600) begin errors++; $display("FAIL lane2_pc_next got %0h exp 600", pc_next); end
    pc_f = 32'h200;
    drive1(32'hB0, 2'b01, 1, 32'h700, 1, 32'h700);
    drive2(32'hB4, 2'b01, 1, 32'h800, 1, 32'h800); #1;
    checks++; if (flush_f !== 1'b0) begin errors++; $display("FAIL taken1_noflush got %0h exp 0", flush_f); end
    tick; idle; pc_f = 32'hB0; #1;
    checks++; if (hit_f1 !== 1'b1) begin errors++; $display("FAIL taken1_alloc got %0h exp 1", hit_f1); end
    checks++; if (hit_f2 !== 1'b0) begin errors++; $display("FAIL taken1_skip2 got %0h exp 0", hit_f2); end
    checks++; if (pc_next !== 32'h700) begin errors++; $display("FAIL taken1_pc_next got %0h exp 700", pc_next); end
  endtask

  task automatic test_stall;
    stall_f = 1; pc_f = 32'hA0;
    drive1(32'hC0, 2'b00, 1, 32'h900, 0, 32'h0); #1;
    checks++; if (flush_f !== 1'b1) begin errors++; $display("FAIL stall_flush got %0h exp 1", flush_f); end
    checks++; if (pc_next !== 32'h900) begin errors++; $display("FAIL stall_redirect got %0h exp 900", pc_next); end
    checks++; if (hit_f2 !== 1'b1) begin errors++; $display("FAIL stall_pred_valid got %0h exp 1", hit_f2); end
    tick; stall_f = 0; idle; pc_f = 32'hC0; #1;
    checks++; if (hit_f1 !== 1'b0) begin errors++; $display("FAIL stall_no_write got %0h exp 0", hit_f1); end
    reset = 1;
    drive1(32'hD0, 2'b01, 1, 32'hA00, 0, 32'h0);
    tick; reset = 0; idle; pc_f = 32'hD0; #1;
    checks++; if (hit_f1 !== 1'b0) begin errors++; $display("FAIL reset_discard got %0h exp 0", hit_f1); end
  endtask

  task automatic test_ras;
    logic [31:0] exp_tgt [5];
`ifdef BP_RAS_EN
    exp_tgt[0] = 32'h54; exp_tgt[1] = 32'h44; exp_tgt[2] = 32'h34; exp_tgt[3] = 32'h24; exp_tgt[4] = 32'hAAA0;
`else
    for (int k = 0; k < 5; k++) exp_tgt[k] = 32'hAAA0;
`endif
    do_reset;
    drive1(32'h608, 2'b11, 1, 32'hAAA0, 0, 32'h0); tick;
    for (int k = 1; k <= 5; k++) begin
      drive1(32'h10 * k, 2'b10, 1, 32'h1000, 1, 32'h1000); tick;
    end
    idle; pc_f = 32'h608; #1;
    checks++; if (pred_f1 !== 1'b1) begin errors++; $display("FAIL ret_pred got %0h exp 1", pred_f1); end
    checks++; if (tgt_f1 !== exp_tgt[0]) begin errors++; $display("FAIL ret_tgt0 got %0h exp %0h", tgt_f1, exp_tgt[0]); end
    checks++; if (pc_next !== exp_tgt[0]) begin errors++; $display("FAIL ret_pc_next got %0h exp %0h", pc_next, exp_tgt[0]); end
    for (int p = 1; p <= 4; p++) begin
      drive1(32'h608, 2'b11, 1, 32'hAAA0, 1, 32'hAAA0); tick; idle; #1;
      checks++; if (tgt_f1 !== exp_tgt[p]) begin errors++; $display("FAIL ret_tgt_pop%0d got %0h exp %0h", p, tgt_f1, exp_tgt[p]); end
    end
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_counter_training;
    test_dual_resolve;
    test_stall;
    test_ras;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_gshare_predictor.md
# dual_gshare_predictor

- Parametrised second-generation branch predictor for the dual-issue front end.
- Combines three structures:
  - a tagged, direct-mapped BTB with branch-type storage;
  - a gshare PHT of 2-bit counters, indexed by PC XOR global history;
  - an optional return-address stack.
- Predicts both fetch lanes combinationally and produces the next fetch PC.
- Resolves up to two branches per cycle from decode and raises the front-end flush on mispredict.

## Interface

Parameters:
- BTB_ENTRIES, 16: BTB entries; power of two, ≥2.
- PHT_BITS, 9: log2 of PHT entries; range 4..12.
- HIST_BITS, 4: global history length; must be ≤ PHT_BITS.
- RAS_DEPTH, 4: return stack entries; power of two.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall_f  in  1  fetch stall; blocks all state updates
- pc_f  in  32  fetch-pair base; lane1 = pc_f, lane2 = pc_f+4
- hit_f1, hit_f2  out  1  BTB hit per lane
- pred_f1, pred_f2  out  1  predicted taken per lane
- tgt_f1, tgt_f2  out  32  predicted target per lane
- pc_next  out  32  next fetch PC
- flush_f  out  1  resolve mispredict; kill fetch/decode
- res_v1, res_v2  in  1  lane holds a resolved branch/jump
- res_pc1, res_pc2  in  32  branch PCs
- res_type1, res_type2  in  2  branch type: 00 cond, 01 jump, 10 call, 11 ret
- res_taken1, res_taken2  in  1  actual direction
- res_tgt1, res_tgt2  in  32  actual target
- res_pred1, res_pred2  in  1  direction predicted at fetch
- res_ptgt1, res_ptgt2  in  32  target predicted at fetch

## Operation

- **BTB.** IDX = log2(BTB_ENTRIES). Index = pc[IDX+1:2]; tag = pc[31:IDX+2]. Each entry holds {valid, tag, target[31:0], type[1:0]}.
- **PHT.** Index = pc[PHT_BITS+1:2] XOR {zero-extended ghr}. Each entry is a 2-bit saturating counter.
- **Lane prediction.** pred = hit & (type≠00 | ctr[1]). tgt = RAS top when the RAS is enabled, type=11 and the RAS is non-empty; otherwise the BTB target.
- **pc_next with no mispredict:**
  - pred_f1 → tgt_f1
  - else pred_f2 → tgt_f2
  - else pc_f+8
- **Mispredict.** Lane mispredict = res_v & (res_taken≠res_pred | (res_taken & res_tgt≠res_ptgt)). Lane1 mispredict squashes lane2: no update and no flush from lane2.
- **Redirect on mispredict.**
  - flush_f=1.
  - pc_next = res_taken ? res_tgt : res_pc+4, taken from the oldest mispredicting lane.
  - A mispredict overrides the fetch prediction.
- **Update (registered, only when ~stall_f), lane1 first, then lane2 if not squashed.** Lane2 is also skipped when lane1 is taken.
  - Cond branch: counter saturates up on taken and down on not-taken. The index uses the ghr at the start of the cycle for both lanes.
  - ghr shifts left with res_taken in bit 0, once per resolved cond branch, so up to 2 shifts per cycle.
  - BTB write when taken and (miss or stored target≠res_tgt or stored type≠res_type). Not-taken branches never allocate.
  - Same-index conflict: lane1's write wins.

## Timing

- Prediction is combinational from pc_f. Updates become visible the cycle after the enabling edge.
- flush_f and the redirected pc_next are combinational in the same cycle the resolve inputs are presented.
- Reset takes effect at one edge and clears:
  - all BTB valid bits;
  - PHT counters to 2'b01 (weakly not-taken);
  - ghr = 0;
  - RAS pointer and count = 0.
- Outputs after reset with res_v1 = res_v2 = 0: hit=0, pred=0, tgt = 0, pc_next = pc_f+8, flush_f=0.
- Reset mid-operation discards any pending update that cycle.
- stall_f=1: no state changes. Prediction outputs and flush_f remain valid.
- Counter saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.

## Configuration

- **BP_RAS_EN defined:** RAS of RAS_DEPTH entries.
  - Push: resolved taken call (type 10) pushes res_pc+4.
  - Pop: resolved ret (type 11) pops.
  - Pointer wraps circularly. Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty leaves the RAS unchanged, and the ret target falls back to the BTB.
  - Lane1 and lane2 push/pop are applied in order within the cycle.
- **Undefined:** no RAS storage. Type 11 behaves as type 01, and calls push nothing.

## Test plan

- **Reset and cold miss:** reset, then pc_f=0x100 → hit_f1=0, pc_next=0x108. Resolve lane1 cond at 0x100, taken to 0x200, res_pred1=0 → flush_f=1, pc_next=0x200. Next cycle pc_f=0x100 → hit_f1=1, tgt_f1=0x200, pred_f1=0 (ctr=10 with the old ghr index, but ghr is now 1, so the index differs).
- **Counter training:** resolve the same cond at 0x40 taken 3 times with ghr held 0 (HIST_BITS=1, interleaving not-taken branches elsewhere) → ctr reaches 11. One not-taken → 10, still predicts taken.
- **Dual resolve:** lane1 mispredicts not-taken at 0x80, lane2 a taken jump → flush_f=1, pc_next=0x84, lane2 causes no BTB write, ghr shifts once.
- **Stall:** stall_f=1 with a mispredicting resolve → flush_f=1, but the BTB/PHT/ghr are unchanged the next cycle.
- **RAS (BP_RAS_EN, RAS_DEPTH=4):** 5 calls from 0x10, 0x20, 0x30, 0x40, 0x50, then a ret at a BTB-hit PC → tgt = 0x54. After 4 more pops the 5th ret target equals the BTB target.
- **Without BP_RAS_EN:** the same ret → tgt_f1 = stored BTB target.
